// File: rtl/seg7_scan_mux.sv
// Six-digit multiplexed seven-segment driver with per-slot dead-time and a once-per-frame input snapshot.
// Optional leading-zero blanking of the tens digits is enabled by defining SEG7_LZB_EN.
module seg7_scan_mux #(
  parameter int DIV  = 50000,
  parameter int DEAD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg_a_dez,
  input  logic [6:0] seg_a_uni,
  input  logic [6:0] seg_b_dez,
  input  logic [6:0] seg_b_uni,
  input  logic [6:0] seg_s_dez,
  input  logic [6:0] seg_s_uni,
  input  logic       cout_som,
  input  logic       cout_sub,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_tick
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  typedef enum logic {ST_DEAD, ST_SHOW} state_t;

  // cnt/idx name the scan position that the output registers load on the next edge.
  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  state_t           state;
  state_t           nxt_state;
  logic             in_dead;
  logic             slot_end;
  logic             frame_end;

  logic [6:0] in_code [6];
  logic [6:0] shadow  [6];
  logic       sh_som;
  logic       sh_sub;
  logic [6:0] cur_code;
  logic [6:0] disp_code;
  logic       dp_next;

  if (DEAD == 0) begin : g_no_dead
    assign in_dead = 1'b0;
  end else begin : g_dead
    localparam logic [CNT_W-1:0] DEAD_C = CNT_W'(DEAD);
    assign in_dead = (cnt < DEAD_C);
  end

  assign slot_end  = (cnt == CNT_MAX);
  assign frame_end = slot_end && (idx == 3'd5);
  assign nxt_state = in_dead ? ST_DEAD : ST_SHOW;

  always_comb begin
    in_code[0] = seg_a_dez;
    in_code[1] = seg_a_uni;
    in_code[2] = seg_b_dez;
    in_code[3] = seg_b_uni;
    in_code[4] = seg_s_dez;
    in_code[5] = seg_s_uni;
  end

  always_comb begin
    cur_code = shadow[0];
    case (idx)
      3'd1:    cur_code = shadow[1];
      3'd2:    cur_code = shadow[2];
      3'd3:    cur_code = shadow[3];
      3'd4:    cur_code = shadow[4];
      3'd5:    cur_code = shadow[5];
      default: cur_code = shadow[0];
    endcase
  end

  always_comb begin
    disp_code = cur_code;
`ifdef SEG7_LZB_EN
    // Tens digits sit in the even slots; a lone zero there is blanked.
    if (!idx[0] && cur_code == 7'b1000000)
      disp_code = 7'b1111111;
`endif
  end

  always_comb begin
    dp_next = 1'b1;
    if (idx == 3'd4)
      dp_next = ~sh_som;
    else if (idx == 3'd5)
      dp_next = ~sh_sub;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= '0;
      state      <= ST_DEAD;
      an         <= 6'b111111;
      seg        <= 7'b1111111;
      dp         <= 1'b1;
      frame_tick <= 1'b0;
      sh_som     <= 1'b0;
      sh_sub     <= 1'b0;
      for (int i = 0; i < 6; i++)
        shadow[i] <= 7'b1111111;
    end else begin
      cnt <= slot_end ? '0 : cnt + CNT_W'(1);
      if (slot_end)
        idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;

      // Anodes move only at a slot start or at the dead-to-show boundary.
      state <= nxt_state;
      if (cnt == '0 || nxt_state != state)
        an <= (nxt_state == ST_DEAD) ? 6'b111111 : ~(6'b000001 << idx);

      seg        <= disp_code;
      dp         <= dp_next;
      frame_tick <= frame_end;

      // The last slot still reads the old shadow; the new frame starts from the fresh one.
      if (frame_end) begin
        sh_som <= cout_som;
        sh_sub <= cout_sub;
        for (int i = 0; i < 6; i++)
          shadow[i] <= in_code[i];
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Bench for seg7_scan_mux: DIV=8 with DEAD=2 and DEAD=0 instances, checked against a frame-level model.
module tb_seg7_scan_mux;

  localparam int DIV  = 8;
  localparam int DEAD = 2;
  localparam int FR   = 6 * DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] a_dez, a_uni, b_dez, b_uni, s_dez, s_uni;
  logic       c_som, c_sub;
  logic [5:0] an0, an1;
  logic [6:0] seg0, seg1;
  logic       dp0, dp1, ft0, ft1;

  int checks = 0;
  int errors = 0;
  int n;

  logic [6:0] m_sh [6];
  logic       m_som, m_sub;

  always #5 clk = ~clk;

  seg7_scan_mux #(.DIV(DIV), .DEAD(DEAD)) dut (
    .clk(clk), .rst(rst),
    .seg_a_dez(a_dez), .seg_a_uni(a_uni), .seg_b_dez(b_dez),
    .seg_b_uni(b_uni), .seg_s_dez(s_dez), .seg_s_uni(s_uni),
    .cout_som(c_som), .cout_sub(c_sub),
    .an(an0), .seg(seg0), .dp(dp0), .frame_tick(ft0)
  );

  seg7_scan_mux #(.DIV(DIV), .DEAD(0)) dut_nd (
    .clk(clk), .rst(rst),
    .seg_a_dez(a_dez), .seg_a_uni(a_uni), .seg_b_dez(b_dez),
    .seg_b_uni(b_uni), .seg_s_dez(s_dez), .seg_s_uni(s_uni),
    .cout_som(c_som), .cout_sub(c_sub),
    .an(an1), .seg(seg1), .dp(dp1), .frame_tick(ft1)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at cycle %0d: got %b, want %b", tag, n, obs, exp);
    end
  endtask

  function automatic logic [6:0] in_code(input int s);
    case (s)
      0: return a_dez;
      1: return a_uni;
      2: return b_dez;
      3: return b_uni;
      4: return s_dez;
      default: return s_uni;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input int s);
    logic [6:0] c;
    c = m_sh[s];
`ifdef SEG7_LZB_EN
    if ((s % 2) == 0 && c == 7'b1000000) c = 7'b1111111;
`endif
    return c;
  endfunction

  function automatic logic [5:0] exp_an(input int pos, input int slot, input int dead);
    logic [5:0] onehot;
    if (pos < dead) return 6'b111111;
    onehot = 6'd1 << slot;
    return ~onehot;
  endfunction

  function automatic logic exp_dp(input int slot);
    if (slot == 4) return ~m_som;
    if (slot == 5) return ~m_sub;
    return 1'b1;
  endfunction

  function automatic logic [6:0] pick_code();
    if ($urandom_range(0, 3) == 0) return 7'b1000000;
    return 7'($urandom);
  endfunction

  task automatic model_reset();
    n = -1;
    m_som = 1'b0;
    m_sub = 1'b0;
    for (int i = 0; i < 6; i++) m_sh[i] = 7'b1111111;
  endtask

  task automatic rand_inputs();
    if ($urandom_range(0, 3) == 0) a_dez = pick_code();
    if ($urandom_range(0, 3) == 0) a_uni = pick_code();
    if ($urandom_range(0, 3) == 0) b_dez = pick_code();
    if ($urandom_range(0, 3) == 0) b_uni = pick_code();
    if ($urandom_range(0, 3) == 0) s_dez = pick_code();
    if ($urandom_range(0, 3) == 0) s_uni = pick_code();
    if ($urandom_range(0, 3) == 0) c_som = 1'($urandom);
    if ($urandom_range(0, 3) == 0) c_sub = 1'($urandom);
  endtask

  // One clock: compare both instances with the model, then take the snapshot in the model.
  task automatic step_check();
    int slot, pos;
    @(posedge clk);
    #1;
    n++;
    slot = (n / DIV) % 6;
    pos  = n % DIV;
    chk("an",       8'(an0),  8'(exp_an(pos, slot, DEAD)));
    chk("an_nd",    8'(an1),  8'(exp_an(pos, slot, 0)));
    chk("seg",      8'(seg0), 8'(exp_seg(slot)));
    chk("seg_nd",   8'(seg1), 8'(exp_seg(slot)));
    chk("dp",       8'(dp0),  8'(exp_dp(slot)));
    chk("dp_nd",    8'(dp1),  8'(exp_dp(slot)));
    chk("ftick",    8'(ft0),  8'((n % FR) == FR - 1));
    chk("ftick_nd", 8'(ft1),  8'((n % FR) == FR - 1));
    if ((n % FR) == FR - 1) begin
      m_som = c_som;
      m_sub = c_sub;
      for (int i = 0; i < 6; i++) m_sh[i] = in_code(i);
    end
  endtask

  initial begin
    a_dez = 7'b1000000;
    a_uni = 7'b0010000;
    b_dez = 7'b0100100;
    b_uni = 7'h11;
    s_dez = 7'b0110000;
    s_uni = 7'b0011001;
    c_som = 1'b1;
    c_sub = 1'b0;
    model_reset();

    @(posedge clk);
    #1;
    chk("rst_an",  8'(an0),  8'h3F);
    chk("rst_seg", 8'(seg0), 8'h7F);
    chk("rst_dp",  8'(dp0),  8'h01);
    chk("rst_ft",  8'(ft0),  8'h00);
    @(negedge clk);
    rst = 1'b0;

    // Directed frames: fixed inputs except one mid-frame change of b_uni.
    repeat (128) begin
      step_check();
      if (n == 2)  chk("an_c2",    8'(an0), 8'(6'b111110));
      if (n == 8)  chk("an_c8",    8'(an0), 8'(6'b111111));
      if (n == 10) chk("an_c10",   8'(an0), 8'(6'b111101));
      if (n == 0)  chk("an_nd_c0", 8'(an1), 8'(6'b111110));
      if (n == 8)  chk("an_nd_c8", 8'(an1), 8'(6'b111101));
      if (n == 47) chk("ft_c47",   8'(ft0), 8'h01);
`ifdef SEG7_LZB_EN
      if (n == 48) chk("lzb_c48",  8'(seg0), 8'(7'b1111111));
`else
      if (n == 48) chk("tens_c48", 8'(seg0), 8'(7'b1000000));
`endif
      if (n == 56)  chk("uni_c56",  8'(seg0), 8'(7'b0010000));
      if (n == 80)  chk("dp_c80",   8'(dp0),  8'h00);
      if (n == 88)  chk("dp_c88",   8'(dp0),  8'h01);
      if (n == 72)  chk("old_c72",  8'(seg0), 8'h11);
      if (n == 95)  chk("ft_c95",   8'(ft0),  8'h01);
      if (n == 120) chk("new_c120", 8'(seg0), 8'h22);
      if (n == 59)  b_uni = 7'h22;
    end

    // Randomized inputs changing between edges.
    repeat (6 * FR) begin
      rand_inputs();
      step_check();
    end

    // Restart and pulse the asynchronous reset in the middle of slot 3.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      a_dez = 7'b0000110; a_uni = 7'b0100100; b_dez = 7'b0110000;
      b_uni = 7'b0011001; s_dez = 7'b0010010; s_uni = 7'b0000010;
    end
    c_som = 1'b1;
    c_sub = 1'b1;
    while (n < 75) step_check();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_an",     8'(an0),  8'h3F);
    chk("arst_seg",    8'(seg0), 8'h7F);
    chk("arst_dp",     8'(dp0),  8'h01);
    chk("arst_ft",     8'(ft0),  8'h00);
    chk("arst_an_nd",  8'(an1),  8'h3F);
    chk("arst_seg_nd", 8'(seg1), 8'h7F);
    @(posedge clk);
    #1;
    chk("arst_hold_an", 8'(an1), 8'h3F);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (2 * FR) begin
      rand_inputs();
      step_check();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
